// File: rtl/adder_arbiter.sv
// adder_arbiter
//
// Shares one registered adder among NREQ requesters. Requests are picked
// with round-robin priority starting at an internal pointer. The sum
// x + y + cin is returned one cycle later on a single backpressured
// response port, tagged with the id of the requester that issued it.
// A saturating counter records every response the consumer takes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, one-hot or zero
//   req_x      packed operand x, requester i at [i*WIDTH +: WIDTH]
//   req_y      packed operand y, same packing
//   req_cin    per-requester carry-in
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     requester index of the current response
//   rsp_sum    x + y + cin with zero-extended operands
//   rsp_zero   high when rsp_sum is zero
//   op_count   responses consumed since reset, saturating

module adder_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int WIDTH  = 8,
    parameter int SWIDTH = WIDTH + 1,
    parameter int CNTW   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [SWIDTH-1:0]     rsp_sum,
    output logic                  rsp_zero,
    output logic [CNTW-1:0]       op_count
);

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [SWIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [CNTW-1:0]   op_count_q, op_count_d;

    logic              slot_free;
    logic              consume;
    logic              grant_valid;
    logic [IDW-1:0]    grant_idx;
    logic [WIDTH-1:0]  grant_x;
    logic [WIDTH-1:0]  grant_y;
    logic              grant_cin;
    logic [SWIDTH-1:0] grant_sum;

    // Round-robin pick. The first loop covers indices from the pointer up
    // to NREQ-1, the second wraps around to the indices below the pointer,
    // so the scan order is ptr, ptr+1, ... modulo NREQ. Reset gates the
    // grant so nothing is offered while the block is held in reset.
    always_comb begin
        slot_free   = rst_n && (!rsp_valid_q || rsp_ready);
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_x     = '0;
        grant_y     = '0;
        grant_cin   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && slot_free && req_valid[i] && (i >= int'(ptr_q))) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(i);
                grant_x     = req_x[i*WIDTH +: WIDTH];
                grant_y     = req_y[i*WIDTH +: WIDTH];
                grant_cin   = req_cin[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && slot_free && req_valid[i] && (i < int'(ptr_q))) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(i);
                grant_x     = req_x[i*WIDTH +: WIDTH];
                grant_y     = req_y[i*WIDTH +: WIDTH];
                grant_cin   = req_cin[i];
            end
        end
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_valid && (grant_idx == IDW'(i));
        end
        grant_sum = SWIDTH'(grant_x) + SWIDTH'(grant_y) + SWIDTH'(grant_cin);
    end

    // A new acceptance always refills the response slot, even in the same
    // cycle the old response is consumed, giving one op per cycle. The
    // pointer wraps at NREQ rather than at 2**IDW.
    always_comb begin
        consume     = rsp_valid_q && rsp_ready;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_zero_d  = rsp_zero_q;
        op_count_d  = op_count_q;
        if (grant_valid) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_sum_d   = grant_sum;
            rsp_zero_d  = (grant_sum == '0);
            ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (consume) begin
            rsp_valid_d = 1'b0;
        end
        if (consume && (op_count_q != {CNTW{1'b1}})) begin
            op_count_d = op_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_zero_q  <= rsp_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = op_count_q;

endmodule
